// File: rtl/seven_seg_scan_n.sv
`default_nettype none
// ============================================================================
//  Module   : seven_seg_scan_n (with helper bin_to_seven_seg)
//  Brief    : N-digit multiplexed seven-segment scanner with leading-zero
//             blanking, 8-level brightness PWM and a frame-synchronous
//             shadow register loaded through a load/ack handshake.
//  Revision : 1.0 - initial release
// ============================================================================

// ----------------------------------------------------------------------------
//  bin_to_seven_seg : hex nibble to active-low segments, bit 0 = a .. bit 6 = g
// ----------------------------------------------------------------------------
module bin_to_seven_seg (
  input  logic [3:0] bin,
  output logic [6:0] seg
);

  // Pure lookup: one glyph per hex digit
  always_comb begin
    seg = 7'h7F;
    case (bin)
      4'h0: seg = 7'h40;
      4'h1: seg = 7'h79;
      4'h2: seg = 7'h24;
      4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;
      4'h5: seg = 7'h12;
      4'h6: seg = 7'h02;
      4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;
      4'h9: seg = 7'h10;
      4'hA: seg = 7'h08;
      4'hB: seg = 7'h03;
      4'hC: seg = 7'h46;
      4'hD: seg = 7'h21;
      4'hE: seg = 7'h06;
      default: seg = 7'h0E;
    endcase
  end

endmodule

// ----------------------------------------------------------------------------
//  seven_seg_scan_n : top-level scanner
// ----------------------------------------------------------------------------
module seven_seg_scan_n #(
  parameter int NDIGITS = 4,
  parameter int SLICE   = 6250
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   enable,
  input  logic [4*NDIGITS-1:0]   value,
  input  logic [NDIGITS-1:0]     dp,
  input  logic                   load,
  output logic                   load_ack,
  input  logic                   blank_lz,
  input  logic [2:0]             brightness,
  output logic [6:0]             segdisplay,
  output logic                   segdp,
  output logic [NDIGITS-1:0]     segselect,
  output logic                   frame_done
);

  localparam int c_SLOT = 8 * SLICE;
  localparam int c_TW   = $clog2(c_SLOT);
  localparam int c_DW   = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;

  logic [c_TW-1:0]        r_tick;
  logic [c_DW-1:0]        r_digit;
  logic                   r_pending;
  logic [4*NDIGITS-1:0]   r_shadow_value;
  logic [NDIGITS-1:0]     r_shadow_dp;

  logic                   w_wrap;
  logic                   w_frame_end;
  logic                   w_on;
  logic [31:0]            w_thresh;
  logic [3:0]             w_nib [NDIGITS];
  logic [NDIGITS-1:0]     w_zero_from;
  logic                   w_blank;
  logic [3:0]             w_cur_nib;
  logic [6:0]             w_cur_seg;
  logic [NDIGITS-1:0]     w_sel_on;

  assign w_wrap      = (r_tick == c_TW'(c_SLOT - 1));
  assign w_frame_end = w_wrap && (r_digit == c_DW'(NDIGITS - 1));

  // On-window length grows by one slice per brightness step
  assign w_thresh = (32'(brightness) + 32'd1) * 32'(SLICE);
  assign w_on     = (32'(r_tick) < w_thresh);

  // Split shadow into nibbles and flag digits whose nibble and all higher
  // nibbles are zero (candidates for leading-zero blanking)
  generate
    for (genvar gi = 0; gi < NDIGITS; gi++) begin : g_nib
      assign w_nib[gi] = r_shadow_value[4*gi +: 4];
      if (gi == NDIGITS - 1) begin : g_top
        assign w_zero_from[gi] = (w_nib[gi] == 4'h0);
      end else begin : g_lower
        assign w_zero_from[gi] = (w_nib[gi] == 4'h0) && w_zero_from[gi+1];
      end
    end
  endgenerate

  assign w_cur_nib = w_nib[r_digit];
  assign w_blank   = blank_lz && (r_digit != '0) && w_zero_from[r_digit];

  bin_to_seven_seg u_dec (
    .bin (w_cur_nib),
    .seg (w_cur_seg)
  );

  // Active-low anode pattern for the current digit
  always_comb begin
    w_sel_on = '1;
    for (int i = 0; i < NDIGITS; i++) begin
      if (r_digit == c_DW'(i)) begin
        w_sel_on[i] = 1'b0;
      end
    end
  end

  // Slot timer and digit index, advancing only while enabled
  always_ff @(posedge clock) begin
    if (reset) begin
      r_tick  <= '0;
      r_digit <= '0;
    end else if (enable) begin
      if (w_wrap) begin
        r_tick <= '0;
        if (r_digit == c_DW'(NDIGITS - 1)) begin
          r_digit <= '0;
        end else begin
          r_digit <= r_digit + c_DW'(1);
        end
      end else begin
        r_tick <= r_tick + c_TW'(1);
      end
    end
  end

  // Load handshake: request latched immediately, shadow copied only at frame end
  always_ff @(posedge clock) begin
    if (reset) begin
      r_pending      <= 1'b0;
      r_shadow_value <= '0;
      r_shadow_dp    <= '0;
    end else if (enable) begin
      if (w_frame_end && r_pending) begin
        r_shadow_value <= value;
        r_shadow_dp    <= dp;
        r_pending      <= 1'b0;
      end else if (load && !r_pending) begin
        r_pending <= 1'b1;
      end
    end
  end

  // Registered display outputs and one-cycle status pulses
  always_ff @(posedge clock) begin
    if (reset) begin
      segselect  <= '1;
      segdisplay <= 7'h7F;
      segdp      <= 1'b1;
      load_ack   <= 1'b0;
      frame_done <= 1'b0;
    end else if (enable) begin
      segselect  <= w_on ? w_sel_on : '1;
      segdisplay <= w_blank ? 7'h7F : w_cur_seg;
      segdp      <= ~r_shadow_dp[r_digit];
      load_ack   <= w_frame_end && r_pending;
      frame_done <= w_frame_end;
    end else begin
      load_ack   <= 1'b0;
      frame_done <= 1'b0;
    end
  end

endmodule
`default_nettype wire
